victim_cache_fa: RTL
====================

# victim_cache_fa

Parametrised, fully associative victim cache between the instruction cache and its memory refill path. It holds lines evicted from the direct-mapped I-cache, answers combinational lookups by full block address, and hands a hit line back to the I-cache exclusively: the entry is invalidated on transfer. Replacement is round-robin FIFO by default, with true LRU selectable at compile time. Entry count and data width are generic.

## Interface
- `NUM_ENTRIES`, 4: number of entries; power of two, 2..16.
- `DATA_BITS`, 64: line payload width.
- `BLK_BITS`, 13: block-address width, taken from `addr[15:3]` (`{tag, index}`).
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: invalidate all entries.
- `evict_en` in 1: the I-cache is evicting a valid line this cycle.
- `evict_blk` in `BLK_BITS`: block address of the evicted line, `{tag, index}`.
- `evict_data` in `DATA_BITS`: payload of the evicted line.
- `lookup_valid` in 1: a real fetch lookup is in progress; qualifies LRU touch.
- `lookup_addr` in `XLEN`: fetch address; `lookup_addr[15:3]` is compared.
- `take_en` in 1: the I-cache accepts the current hit line; the hit entry is invalidated.
- `hit` out 1: a valid entry matches `lookup_addr[15:3]`.
- `hit_data` out `DATA_BITS`: payload of the matching entry; 0 when `hit`=0.
- `hit_way` out `$clog2(NUM_ENTRIES)`: index of the matching entry; 0 when no hit.
- `occupancy` out `$clog2(NUM_ENTRIES)+1`: count of valid entries.

## Operation
- Each entry holds {valid, blk, data}. On reset or `flush`, all valid bits are cleared, the FIFO pointer and LRU state go to 0, and `occupancy`=0. Data and blk contents are don't-care.
- Lookup is purely combinational on the current registered state. At most one entry matches, which is guaranteed by the duplicate-evict rule below.
- Take: when `take_en`=1 and `hit`=1, the entry at `hit_way` has its valid bit cleared at the edge. `take_en` with `hit`=0 is ignored.
- Evict allocation is evaluated against the pre-edge state, in this order:
  - If `evict_blk` matches a valid entry, that entry is overwritten. No new slot is used.
  - Otherwise, the lowest-index invalid entry is used.
  - Otherwise, when the cache is full, the replacement victim is used: the FIFO entry at `rr_ptr`, or the LRU entry.
- The FIFO pointer `rr_ptr` advances by 1, modulo `NUM_ENTRIES`, only when a full cache replaces an entry.
- Simultaneous take and evict to different entries: both are applied. If both target the same entry, the evict wins: the entry is valid with the new blk and data.
- A take does not free a slot for a same-cycle evict. The evict still sees the pre-edge full state and replaces the victim.
- Precedence: `reset` > `flush` > evict > take.
- `occupancy` updates at the edge with net effect (+1 for a new allocation, -1 for a take that is not overridden), and is saturated to the range 0..`NUM_ENTRIES`.

## Timing
- Lookup latency is 0 cycles: `hit`, `hit_data` and `hit_way` are valid in the same cycle as `lookup_addr`.
- Updates are visible one cycle after the edge. There is no bypass, so an evict in cycle N cannot hit a lookup until cycle N+1.
- There are no stalls or backpressure. An evict is always accepted in one cycle.
- A reset asserted mid-stream discards any same-cycle evict or take.

## Configuration
- `VCACHE_LRU_EN` undefined: round-robin FIFO replacement uses `rr_ptr`. `lookup_valid` is functionally unused.
- `VCACHE_LRU_EN` defined: true LRU replacement.
  - An entry is touched (made MRU) when it is allocated by an evict, and on a lookup hit with `lookup_valid`=1 and `take_en`=0.
  - A take leaves the entry LRU-eligible.
  - The victim is the least recently touched entry. Ties after reset resolve to the lowest index.
  - `rr_ptr` is not instantiated.

## Structure
- Shared package (sys_defs):
  - `VCACHE_ENTRY` typedef {valid, blk, data}.
  - `VC_NUM_ENTRIES` default constant.
  - `VC_BLK_BITS`, replacing the ad hoc `12-CACHE_LINE_BITS` arithmetic.
- Sub-module `vcache_lru`, present only under `VCACHE_LRU_EN`:
  - Per-entry age counters of `$clog2(NUM_ENTRIES)` bits.
  - Inputs: `touch_en`, `touch_way`.
  - Output: `lru_way`.
- The top level contains the entry array, the match and priority encoders, the allocation logic, `rr_ptr` and `occupancy`.

## Test plan
- Reset, then look up 0x0000_1008 -> `hit`=0, `hit_data`=0, `occupancy`=0.
- Evict blk 0x0201 with data 0xDEAD_BEEF_0000_0001, then next cycle look up 0x0000_1008 -> `hit`=1, `hit_way`=0, data matches, `occupancy`=1. In the same cycle as the evict, `hit`=0.
- FIFO mode: evict 5 distinct blks A..E with `NUM_ENTRIES`=4 -> E replaces A in way 0. A lookup of A misses and `occupancy`=4. A 6th evict replaces way 1.
- Hit on blk B, then `take_en` -> next cycle `hit`=0 for B and `occupancy`=3. A following new evict fills the freed way.
- Evict blk C twice with different data -> one entry holds the second data and `occupancy` is unchanged. Same-cycle take plus evict of the same blk -> the entry is valid with the new data.
- LRU mode: fill A..D, then do a `lookup_valid` hit on A, then evict E -> B is replaced and A still hits. `flush` -> `occupancy`=0 and all lookups miss.

Source files
------------

// File: rtl/victim_cache_fa_pkg.sv
// Shared victim-cache definitions: geometry defaults, the entry record and a popcount helper.
package victim_cache_fa_pkg;

    localparam int XLEN           = 32;
    localparam int VC_OFFSET_BITS = 3;
    localparam int VC_ADDR_BITS   = 16;
    localparam int VC_BLK_BITS    = VC_ADDR_BITS - VC_OFFSET_BITS;
    localparam int VC_NUM_ENTRIES = 4;
    localparam int VC_DATA_BITS   = 64;

    typedef struct packed {
        logic                    valid;
        logic [VC_BLK_BITS-1:0]  blk;
        logic [VC_DATA_BITS-1:0] data;
    } VCACHE_ENTRY;

    // Entry counts never exceed 16, so a 16-bit vector and 5-bit result cover every size.
    function automatic logic [4:0] vc_popcount(input logic [15:0] vec);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'd0, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/vcache_lru.sv
// True-LRU tracker for the victim cache: per-entry ages, 0 = most recently touched.
module vcache_lru #(
    parameter int NUM_ENTRIES = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           touch_en,
    input  logic [$clog2(NUM_ENTRIES)-1:0] touch_way,
    output logic [$clog2(NUM_ENTRIES)-1:0] lru_way
);

    localparam int WAY_BITS = $clog2(NUM_ENTRIES);

    logic [WAY_BITS-1:0] age_r [NUM_ENTRIES];

    // Touched entries hold distinct ages in recency order; never-touched ones share the oldest age.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (reset || flush) begin
                age_r[i] <= '0;
            end else if (touch_en && (WAY_BITS'(i) == touch_way)) begin
                age_r[i] <= '0;
            end else if (touch_en && (age_r[i] <= age_r[touch_way])) begin
                age_r[i] <= age_r[i] + WAY_BITS'(1);
            end else begin
                age_r[i] <= age_r[i];
            end
        end
    end

    // Oldest entry wins; a strict compare keeps ties on the lowest index.
    always_comb begin
        logic [WAY_BITS-1:0] best_age_s;
        lru_way    = '0;
        best_age_s = age_r[0];
        for (int i = 1; i < NUM_ENTRIES; i++) begin
            lru_way    = (age_r[i] > best_age_s) ? WAY_BITS'(i) : lru_way;
            best_age_s = (age_r[i] > best_age_s) ? age_r[i] : best_age_s;
        end
    end

endmodule

// File: rtl/victim_cache_fa.sv
// Fully associative victim cache behind the I-cache with exclusive hand-back on take.
// Replacement is round-robin FIFO unless VCACHE_LRU_EN is defined, which selects true LRU.
module victim_cache_fa
    import victim_cache_fa_pkg::*;
#(
    parameter int NUM_ENTRIES = VC_NUM_ENTRIES,
    parameter int DATA_BITS   = VC_DATA_BITS,
    parameter int BLK_BITS    = VC_BLK_BITS
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           evict_en,
    input  logic [BLK_BITS-1:0]            evict_blk,
    input  logic [DATA_BITS-1:0]           evict_data,
    input  logic                           lookup_valid,
    input  logic [XLEN-1:0]                lookup_addr,
    input  logic                           take_en,
    output logic                           hit,
    output logic [DATA_BITS-1:0]           hit_data,
    output logic [$clog2(NUM_ENTRIES)-1:0] hit_way,
    output logic [$clog2(NUM_ENTRIES):0]   occupancy
);

    localparam int WAY_BITS = $clog2(NUM_ENTRIES);
    typedef logic [WAY_BITS-1:0] way_t;

    logic [NUM_ENTRIES-1:0] valid_r;
    logic [BLK_BITS-1:0]    blk_r  [NUM_ENTRIES];
    logic [DATA_BITS-1:0]   data_r [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0] hit_vec_s, evict_vec_s, valid_next_s, take_mask_s, alloc_mask_s;
    logic [BLK_BITS-1:0]    lookup_blk_s;
    logic                   evict_match_s, full_s;
    way_t                   victim_way_s, alloc_way_s;
    logic                   unused_addr_s;

    function automatic way_t first_set(input logic [NUM_ENTRIES-1:0] vec);
        way_t idx;
        idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            idx = vec[i] ? way_t'(i) : idx;
        end
        return idx;
    endfunction

    function automatic logic [NUM_ENTRIES-1:0] one_hot(input way_t way);
        return {{(NUM_ENTRIES-1){1'b0}}, 1'b1} << way;
    endfunction

    assign lookup_blk_s  = lookup_addr[BLK_BITS+VC_OFFSET_BITS-1:VC_OFFSET_BITS];
    assign unused_addr_s = ^{lookup_addr[XLEN-1:BLK_BITS+VC_OFFSET_BITS],
                             lookup_addr[VC_OFFSET_BITS-1:0]};

    // Match both the fetch address and the evicted block against every valid entry.
    always_comb begin
        hit_vec_s   = '0;
        evict_vec_s = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            hit_vec_s[i]   = valid_r[i] && (blk_r[i] == lookup_blk_s);
            evict_vec_s[i] = valid_r[i] && (blk_r[i] == evict_blk);
        end
        hit           = |hit_vec_s;
        hit_way       = first_set(hit_vec_s);
        hit_data      = hit ? data_r[hit_way] : '0;
        evict_match_s = |evict_vec_s;
        full_s        = &valid_r;
    end

    // Evict slot: existing copy first, then lowest free slot, then the replacement victim.
    always_comb begin
        alloc_way_s  = evict_match_s ? first_set(evict_vec_s)
                     : (full_s ? victim_way_s : first_set(~valid_r));
        take_mask_s  = (take_en && hit) ? one_hot(hit_way) : '0;
        alloc_mask_s = evict_en ? one_hot(alloc_way_s) : '0;
        valid_next_s = (valid_r & ~take_mask_s) | alloc_mask_s;
    end

    // Valid bits and occupancy; the evict mask is applied after the take so it wins on the same entry.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            valid_r   <= '0;
            occupancy <= '0;
        end else begin
            valid_r   <= valid_next_s;
            occupancy <= (WAY_BITS+1)'(vc_popcount(16'(valid_next_s)));
        end
    end

    // Payload storage carries no reset; only the valid bits qualify it.
    always_ff @(posedge clock) begin
        if (evict_en && !reset && !flush) begin
            blk_r[alloc_way_s]  <= evict_blk;
            data_r[alloc_way_s] <= evict_data;
        end
    end

`ifdef VCACHE_LRU_EN
    logic touch_en_s;
    way_t touch_way_s, lru_way_s;

    assign touch_en_s  = evict_en || (lookup_valid && hit && !take_en);
    assign touch_way_s = evict_en ? alloc_way_s : hit_way;

    vcache_lru #(
        .NUM_ENTRIES (NUM_ENTRIES)
    ) u_lru (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .touch_en  (touch_en_s),
        .touch_way (touch_way_s),
        .lru_way   (lru_way_s)
    );

    assign victim_way_s = lru_way_s;
`else
    way_t rr_ptr_r;
    logic replace_s;
    logic unused_s;

    assign replace_s    = evict_en && !evict_match_s && full_s;
    assign victim_way_s = rr_ptr_r;
    assign unused_s     = lookup_valid;

    // Round-robin pointer moves only when a full cache displaces an entry.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rr_ptr_r <= '0;
        end else if (replace_s) begin
            rr_ptr_r <= rr_ptr_r + way_t'(1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`endif

endmodule
